// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for a 32-bit data memory.
// Turns an RV32 size/sign code and the low address bits into write strobes and
// replicated store data. It also extends the load data and flags misaligned or
// illegal accesses.
module dmem_lane_align
  import dmem_arb_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr_lo,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data,
  output logic        err
);

  logic [31:0] shifted;

  // Shift the addressed lane down to bit 0, then size, extend and check the access.
  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = wdata;
    load_data = 32'h0;
    err       = 1'b0;
    shifted   = rdata_raw >> {addr_lo, 3'b000};
    case (func3)
      F3_B, F3_BU: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        load_data = func3[2] ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        wstrb     = 4'b0011 << addr_lo;
        wdata_rep = {2{wdata[15:0]}};
        load_data = func3[2] ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        err       = addr_lo[0];
      end
      F3_W: begin
        wstrb     = 4'b1111;
        load_data = shifted;
        err       = (addr_lo != 2'b00);
      end
      default: begin
        err = 1'b1;
      end
    endcase
    // Stores have no sign variant, so the unsigned codes are illegal for them.
    if (we && func3[2]) begin
      err = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port data-memory sequencer.
// It arbitrates between the core LSU (port C) and a DMA/debug master (port D),
// runs one memory access and returns an extended response pulse.
// Tie-break: define DMEM_ARB_RR_EN for round-robin. Without it, port C wins every tie.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N  = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [N-1:0]  c_wdata,
  input  logic [2:0]    c_func3,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [N-1:0]  d_wdata,
  input  logic [2:0]    d_func3,
  output logic          c_gnt,
  output logic          d_gnt,
  output logic          c_rvalid,
  output logic          d_rvalid,
  output logic [N-1:0]  c_rdata,
  output logic [N-1:0]  d_rdata,
  output logic          c_err,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  output logic [3:0]    mem_wstrb,
  input  logic [N-1:0]  mem_rdata
);

  state_t        state_q, state_d;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [N-1:0]  lat_wdata;
  logic [2:0]    lat_func3;
  port_t         lat_port;
  logic [N-1:0]  resp_data;
  logic          resp_err;
  logic          can_grant;
  logic          prefer_c;
  logic          in_access;
  logic          access_ok;
  logic          resp_on;
  logic [3:0]    al_wstrb;
  logic [N-1:0]  al_wdata;
  logic [N-1:0]  al_load;
  logic          al_err;

  dmem_lane_align u_align (
    .func3     (lat_func3),
    .addr_lo   (lat_addr[1:0]),
    .we        (lat_we),
    .wdata     (lat_wdata),
    .rdata_raw (mem_rdata),
    .wstrb     (al_wstrb),
    .wdata_rep (al_wdata),
    .load_data (al_load),
    .err       (al_err)
  );

`ifdef DMEM_ARB_RR_EN
  port_t last_q;

  // Remember the most recent winner so the other port takes the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= PORT_D;
    end else if (c_gnt) begin
      last_q <= PORT_C;
    end else if (d_gnt) begin
      last_q <= PORT_D;
    end
  end

  assign prefer_c = (last_q == PORT_D);
`else
  assign prefer_c = 1'b1;
`endif

  // Grant only while no access is pending: in IDLE, or in RESP for back-to-back requests.
  always_comb begin
    can_grant = !reset && ((state_q == IDLE) || (state_q == RESP));
    c_gnt     = can_grant && c_req && (!d_req || prefer_c);
    d_gnt     = can_grant && d_req && !c_gnt;
  end

  // Next-state logic: a grant always leads to one ACCESS cycle followed by RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESP: state_d = (c_gnt || d_gnt) ? ACCESS : IDLE;
      ACCESS:     state_d = RESP;
      default:    state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the winning request on its grant edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_func3 <= 3'b000;
      lat_port  <= PORT_C;
    end else if (c_gnt) begin
      lat_we    <= c_we;
      lat_addr  <= c_addr;
      lat_wdata <= c_wdata;
      lat_func3 <= c_func3;
      lat_port  <= PORT_C;
    end else if (d_gnt) begin
      lat_we    <= d_we;
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_func3 <= d_func3;
      lat_port  <= PORT_D;
    end
  end

  // Register the response at the end of ACCESS. Stores and errors return zero data.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else if (state_q == ACCESS) begin
      resp_err  <= al_err;
      resp_data <= (al_err || lat_we) ? '0 : al_load;
    end
  end

  // Memory strobes are gated by reset and by the error flag, so a bad access never reaches the array.
  always_comb begin
    in_access = (state_q == ACCESS) && !reset;
    access_ok = in_access && !al_err;
    mem_en    = access_ok;
    mem_we    = access_ok && lat_we;
    mem_addr  = in_access ? {lat_addr[AW-1:2], 2'b00} : '0;
    mem_wstrb = mem_we ? al_wstrb : 4'b0000;
    mem_wdata = mem_we ? al_wdata : '0;
  end

  // Steer the response pulse to the port that owns the latched request.
  always_comb begin
    resp_on  = (state_q == RESP) && !reset;
    c_rvalid = resp_on && (lat_port == PORT_C);
    d_rvalid = resp_on && (lat_port == PORT_D);
    c_rdata  = c_rvalid ? resp_data : '0;
    d_rdata  = d_rvalid ? resp_data : '0;
    c_err    = c_rvalid && resp_err;
    d_err    = d_rvalid && resp_err;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter.
// A transaction-level model predicts the grants, memory strobes and responses
// from the access rules. A byte-addressed reference memory supplies the load values.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_req = 1'b0, d_req = 1'b0;
  logic        c_we = 1'b0, d_we = 1'b0;
  logic [31:0] c_addr = '0, d_addr = '0;
  logic [31:0] c_wdata = '0, d_wdata = '0;
  logic [2:0]  c_func3 = '0, d_func3 = '0;
  logic        c_gnt, d_gnt, c_rvalid, d_rvalid, c_err, d_err;
  logic [31:0] c_rdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  dmem_port_arbiter #(.N(32), .AW(32)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_func3(c_func3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
    .c_gnt(c_gnt), .d_gnt(d_gnt), .c_rvalid(c_rvalid), .d_rvalid(d_rvalid),
    .c_rdata(c_rdata), .d_rdata(d_rdata), .c_err(c_err), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    bit          has_lit;
    logic [31:0] lit_rdata;
    bit          lit_err;
    bit          has_lit_wr;
    logic [3:0]  lit_strb;
    logic [31:0] lit_wdata;
  } txn_t;

  logic [31:0] env_mem [0:127];
  logic [7:0]  ref_bytes [0:511];

  assign mem_rdata = env_mem[mem_addr[8:2]];

  txn_t c_script[$], d_script[$];
  txn_t c_cur, d_cur, inf;
  bit   c_has, d_has, inf_valid, inf_is_d;
  int   inf_age;
  logic [31:0] inf_rdata;
  bit   inf_err;
  bit   last_d = 1'b1;
  bit   random_en, reset_arm, force_reset = 1'b1, post_reset, rec_grants;
  int   grant_log[$];
  bit          wr_pend;
  logic [6:0]  wr_idx;
  logic [3:0]  wr_strb;
  logic [31:0] wr_data;
  int   tests = 0;
  int   failed = 0;

  function automatic int sizeOf(logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit refError(txn_t t);
    int sz = sizeOf(t.func3);
    if (sz == 0) return 1'b1;
    if ((int'(t.addr[1:0]) % sz) != 0) return 1'b1;
    if (t.we && t.func3[2]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] refLoad(txn_t t);
    int sz = sizeOf(t.func3);
    logic [31:0] v = 32'h0;
    logic [8:0]  idx;
    for (int i = 0; i < sz; i++) begin
      idx = t.addr[8:0] + 9'(i);
      v[8*i +: 8] = ref_bytes[idx];
    end
    if (!t.func3[2] && sz < 4 && v[8*sz-1]) begin
      for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  function automatic txn_t mk(bit we, logic [31:0] addr, logic [31:0] wdata, logic [2:0] f3);
    txn_t t = '{default: '0};
    t.we = we; t.addr = addr; t.wdata = wdata; t.func3 = f3;
    return t;
  endfunction

  task automatic setWord(logic [6:0] idx, logic [31:0] val);
    env_mem[idx] = val;
    for (int j = 0; j < 4; j++) ref_bytes[{idx, 2'(j)}] = val[8*j +: 8];
  endtask

  task automatic compareValue(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic newRandom(output txn_t t);
    int r, sz;
    logic [2:0] f;
    t = '{default: '0};
    r = int'($urandom_range(0, 11));
    case (r)
      0, 1:    f = 3'b000;
      2, 3:    f = 3'b001;
      4, 5:    f = 3'b010;
      6, 7:    f = 3'b100;
      8, 9:    f = 3'b101;
      10:      f = 3'b011;
      default: f = ($urandom_range(0, 1) == 0) ? 3'b110 : 3'b111;
    endcase
    t.func3 = f;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = 32'($urandom_range(0, 511));
    sz      = sizeOf(f);
    if (sz > 0 && $urandom_range(0, 3) != 0) t.addr = t.addr - 32'(int'(t.addr[1:0]) % sz);
    t.wdata = $urandom;
  endtask

  // Present the next scripted or random request on each idle port. Requests stay up until granted.
  task automatic applyStimulus();
    reset = force_reset;
    if (reset_arm && inf_valid && inf_age == 1) begin
      reset = 1'b1;
      reset_arm = 1'b0;
    end
    if (!c_has) begin
      if (c_script.size() > 0) begin c_cur = c_script.pop_front(); c_has = 1'b1; end
      else if (random_en && $urandom_range(0, 2) == 0) begin newRandom(c_cur); c_has = 1'b1; end
    end
    if (!d_has) begin
      if (d_script.size() > 0) begin d_cur = d_script.pop_front(); d_has = 1'b1; end
      else if (random_en && $urandom_range(0, 2) == 0) begin newRandom(d_cur); d_has = 1'b1; end
    end
    c_req = c_has; c_we = c_cur.we; c_addr = c_cur.addr; c_wdata = c_cur.wdata; c_func3 = c_cur.func3;
    d_req = d_has; d_we = d_cur.we; d_addr = d_cur.addr; d_wdata = d_cur.wdata; d_func3 = d_cur.func3;
  endtask

  // Compare every DUT output against the model for this cycle, then advance the model by one edge.
  task automatic checkOutput();
    bit can, pref_c, eg_c, eg_d, e_err, resp;
    int sz;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
    wr_pend = mem_en && mem_we;
    wr_idx  = mem_addr[8:2];
    wr_strb = mem_wstrb;
    wr_data = mem_wdata;
    if (reset) begin
      compareValue("rst_c_gnt", 32'(c_gnt), 0);
      compareValue("rst_d_gnt", 32'(d_gnt), 0);
      compareValue("rst_mem_en", 32'(mem_en), 0);
      compareValue("rst_mem_we", 32'(mem_we), 0);
      compareValue("rst_c_rvalid", 32'(c_rvalid), 0);
      compareValue("rst_d_rvalid", 32'(d_rvalid), 0);
      inf_valid  = 1'b0;
      last_d     = 1'b1;
      post_reset = 1'b1;
    end else begin
      if (post_reset) begin
        compareValue("post_rst_c_rvalid", 32'(c_rvalid), 0);
        compareValue("post_rst_d_rvalid", 32'(d_rvalid), 0);
        compareValue("post_rst_c_rdata", c_rdata, 0);
        compareValue("post_rst_d_rdata", d_rdata, 0);
        compareValue("post_rst_c_err", 32'(c_err), 0);
        compareValue("post_rst_d_err", 32'(d_err), 0);
        compareValue("post_rst_mem_addr", mem_addr, 0);
        compareValue("post_rst_mem_wstrb", 32'(mem_wstrb), 0);
        post_reset = 1'b0;
      end
      can = !inf_valid || inf_age == 2;
`ifdef DMEM_ARB_RR_EN
      pref_c = last_d;
`else
      pref_c = 1'b1;
`endif
      eg_c = can && c_has && (!d_has || pref_c);
      eg_d = can && d_has && !eg_c;
      compareValue("c_gnt", 32'(c_gnt), 32'(eg_c));
      compareValue("d_gnt", 32'(d_gnt), 32'(eg_d));
      if (rec_grants) begin
        if (c_gnt) grant_log.push_back(0);
        if (d_gnt) grant_log.push_back(1);
      end
      if (inf_valid && inf_age == 1) begin
        e_err = refError(inf);
        compareValue("mem_en", 32'(mem_en), 32'(!e_err));
        compareValue("mem_we", 32'(mem_we), 32'(!e_err && inf.we));
        if (!e_err) compareValue("mem_addr", mem_addr, {inf.addr[31:2], 2'b00});
        if (!e_err && inf.we) begin
          sz = sizeOf(inf.func3);
          e_strb = 4'b0000;
          for (int i = 0; i < sz; i++) e_strb[int'(inf.addr[1:0]) + i] = 1'b1;
          for (int j = 0; j < 4; j++) e_wd[8*j +: 8] = inf.wdata[8*(j % sz) +: 8];
          compareValue("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
          compareValue("mem_wdata", mem_wdata, e_wd);
        end
        if (inf.has_lit_wr) begin
          compareValue("lit_mem_wstrb", 32'(mem_wstrb), 32'(inf.lit_strb));
          compareValue("lit_mem_wdata", mem_wdata, inf.lit_wdata);
        end
      end else begin
        compareValue("idle_mem_en", 32'(mem_en), 0);
        compareValue("idle_mem_we", 32'(mem_we), 0);
        compareValue("idle_mem_wstrb", 32'(mem_wstrb), 0);
        compareValue("idle_mem_wdata", mem_wdata, 0);
      end
      resp = inf_valid && inf_age == 2;
      compareValue("c_rvalid", 32'(c_rvalid), 32'(resp && !inf_is_d));
      compareValue("d_rvalid", 32'(d_rvalid), 32'(resp && inf_is_d));
      if (resp) begin
        compareValue("rdata", inf_is_d ? d_rdata : c_rdata, inf_rdata);
        compareValue("err", 32'(inf_is_d ? d_err : c_err), 32'(inf_err));
        if (inf.has_lit) begin
          compareValue("lit_rdata", inf_is_d ? d_rdata : c_rdata, inf.lit_rdata);
          compareValue("lit_err", 32'(inf_is_d ? d_err : c_err), 32'(inf.lit_err));
        end
      end
      if (inf_valid && inf_age == 1) begin
        inf_err   = refError(inf);
        inf_rdata = (inf_err || inf.we) ? 32'h0 : refLoad(inf);
        if (!inf_err && inf.we) begin
          sz = sizeOf(inf.func3);
          for (int i = 0; i < sz; i++) ref_bytes[inf.addr[8:0] + 9'(i)] = inf.wdata[8*i +: 8];
        end
        inf_age = 2;
      end else if (inf_valid && inf_age == 2) begin
        inf_valid = 1'b0;
      end
      if (eg_c) begin
        inf = c_cur; inf_is_d = 1'b0; inf_valid = 1'b1; inf_age = 1; c_has = 1'b0; last_d = 1'b0;
      end else if (eg_d) begin
        inf = d_cur; inf_is_d = 1'b1; inf_valid = 1'b1; inf_age = 1; d_has = 1'b0; last_d = 1'b1;
      end
    end
  endtask

  task automatic doCycle();
    @(negedge clk);
    applyStimulus();
    #1;
    checkOutput();
    @(posedge clk);
    #1;
    if (wr_pend) begin
      for (int j = 0; j < 4; j++) begin
        if (wr_strb[j]) env_mem[wr_idx][8*j +: 8] = wr_data[8*j +: 8];
      end
    end
  endtask

  task automatic runUntilIdle(int limit);
    int n = 0;
    while ((c_script.size() > 0 || d_script.size() > 0 || c_has || d_has || inf_valid) && n < limit) begin
      doCycle();
      n++;
    end
    if (c_script.size() > 0 || d_script.size() > 0 || c_has || d_has || inf_valid) begin
      tests++;
      failed++;
      $display("[TB] FAIL drain_timeout: still busy after %0d cycles, required idle", limit);
    end
  endtask

  initial begin
    txn_t t;
    int exp_order[3];
    for (int i = 0; i < 128; i++) setWord(7'(i), $urandom);
    setWord(7'h40, 32'hDEADBEEF);
    setWord(7'h10, 32'h11223344);

    doCycle();
    doCycle();
    force_reset = 1'b0;

    // Tie right after reset: both ports hold requests for three grants each.
    rec_grants = 1'b1;
    for (int i = 0; i < 3; i++) begin
      c_script.push_back(mk(1'b0, 32'(4*i), 32'h0, 3'b010));
      d_script.push_back(mk(1'b0, 32'(16 + 4*i), 32'h0, 3'b010));
    end
    runUntilIdle(100);
    rec_grants = 1'b0;
`ifdef DMEM_ARB_RR_EN
    exp_order = '{0, 1, 0};
`else
    exp_order = '{0, 0, 0};
`endif
    for (int i = 0; i < 3; i++) begin
      compareValue($sformatf("tie_grant_%0d", i), (grant_log.size() > i) ? 32'(grant_log[i]) : 32'hFFFFFFFF, 32'(exp_order[i]));
    end

    // C load word.
    t = mk(1'b0, 32'h100, 32'h0, 3'b010); t.has_lit = 1'b1; t.lit_rdata = 32'hDEADBEEF; t.lit_err = 1'b0;
    c_script.push_back(t);
    runUntilIdle(50);

    // D store byte, then signed and unsigned byte reads.
    t = mk(1'b1, 32'h103, 32'h000000A5, 3'b000); t.has_lit_wr = 1'b1; t.lit_strb = 4'b1000; t.lit_wdata = 32'hA5A5A5A5;
    d_script.push_back(t);
    t = mk(1'b0, 32'h103, 32'h0, 3'b000); t.has_lit = 1'b1; t.lit_rdata = 32'hFFFFFFA5; t.lit_err = 1'b0;
    d_script.push_back(t);
    t = mk(1'b0, 32'h103, 32'h0, 3'b100); t.has_lit = 1'b1; t.lit_rdata = 32'h000000A5; t.lit_err = 1'b0;
    d_script.push_back(t);
    runUntilIdle(50);

    // Misaligned word and halfword loads.
    t = mk(1'b0, 32'h102, 32'h0, 3'b010); t.has_lit = 1'b1; t.lit_rdata = 32'h0; t.lit_err = 1'b1;
    c_script.push_back(t);
    t = mk(1'b0, 32'h101, 32'h0, 3'b001); t.has_lit = 1'b1; t.lit_rdata = 32'h0; t.lit_err = 1'b1;
    c_script.push_back(t);
    // Back-to-back loads from C.
    c_script.push_back(mk(1'b0, 32'h100, 32'h0, 3'b010));
    c_script.push_back(mk(1'b0, 32'h042, 32'h0, 3'b101));
    runUntilIdle(50);

    // Reset during the ACCESS cycle of a store, followed by a read-back of the untouched word.
    reset_arm = 1'b1;
    c_script.push_back(mk(1'b1, 32'h40, 32'hCAFEF00D, 3'b010));
    t = mk(1'b0, 32'h40, 32'h0, 3'b010); t.has_lit = 1'b1; t.lit_rdata = 32'h11223344; t.lit_err = 1'b0;
    c_script.push_back(t);
    runUntilIdle(50);
    compareValue("reset_fired", 32'(reset_arm), 0);

    // Randomized traffic on both ports.
    random_en = 1'b1;
    repeat (3000) doCycle();
    random_en = 1'b0;
    runUntilIdle(100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-port sequencer in front of the data memory. It arbitrates between the core load/store unit (port C) and a DMA/debug master (port D), and registers the winning request. It drives one memory access with byte strobes, then returns aligned, sign- or zero-extended load data through a valid pulse. Misaligned or illegal accesses are rejected here with an error response and never reach the memory array.

## Interface
Parameters:
- N, 32, data width (byte-lane logic fixed at 4 lanes; N=32 only)
- AW, 32, address width

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- c_req, d_req  in  1  request from port C / port D, held until granted
- c_we, d_we  in  1  1 = store, 0 = load
- c_addr, d_addr  in  AW  byte address
- c_wdata, d_wdata  in  N  store data, right-justified
- c_func3, d_func3  in  3  RV32 size/sign code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- c_gnt, d_gnt  out  1  combinational grant, one cycle; request is captured on that edge
- c_rvalid, d_rvalid  out  1  one-cycle completion pulse, loads and stores
- c_rdata, d_rdata  out  N  extended load data, valid with rvalid; 0 for stores and errors
- c_err, d_err  out  1  misaligned/illegal flag, valid with rvalid
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  AW  word-aligned address, bits [1:0] = 0
- mem_wdata  out  N  lane-replicated store data
- mem_wstrb  out  4  byte-lane write strobes
- mem_rdata  in  N  raw word from memory, combinational read of mem_addr

## Operation
- FSM states: IDLE, ACCESS, RESP.
- Grant is evaluated in IDLE and RESP only.
- On a grant, the edge latches we, addr, wdata, func3 and the port ID, and the next state is ACCESS. With no grant, the next state is IDLE.
- ACCESS: mem_en = 1 unless the latched request is in error. Memory writes at the end of ACCESS. mem_rdata is extracted, extended and registered. Next state is RESP.
- RESP: rvalid, rdata and err are driven to the latched port only. Back-to-back requests are allowed, so peak throughput is one access per 2 cycles.
- Error conditions:
  - func3[1:0] = 11
  - func3 = 110 or 111
  - halfword with addr[0] = 1
  - word with addr[1:0] != 0
  - store with func3[2] = 1
- On error: no mem_en, rdata = 0, err = 1.
- Store strobes:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
- Store data: byte replicated into 4 lanes, half into 2 lanes, word passed through.
- Load: select the lane by addr[1:0]. func3[2] = 0 sign-extends; func3[2] = 1 zero-extends.
- Simultaneous c_req and d_req: priority follows Configuration. A port whose request is not granted keeps req high and is reconsidered in the next IDLE/RESP cycle.

## Timing
- Load latency: req and gnt in cycle 0, memory access in cycle 1, rvalid in cycle 2.
- Reset values:
  - state = IDLE
  - all gnt, rvalid, err, mem_en, mem_we = 0
  - rdata, mem_addr, mem_wdata = 0
  - mem_wstrb = 0000
  - last-granted = D, so C wins the first tie
- Reset mid-operation: the transaction is dropped with no rvalid. mem_en and mem_we are gated by !reset in the same cycle, so no write occurs during a reset cycle.
- mem_we, mem_wstrb and mem_wdata are all 0 outside ACCESS.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. On a tie, grant goes to the port not granted most recently. The last-granted register updates on every grant.
- DMEM_ARB_RR_EN undefined: fixed priority, C always wins ties. D can starve; this is accepted. The last-granted register is not built.

## Structure
- Package dmem_arb_pkg holds:
  - state enum: IDLE, ACCESS, RESP
  - port-ID enum: PORT_C, PORT_D
  - func3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU
- One combinational sub-module, dmem_lane_align. It takes func3 and addr[1:0] and produces:
  - wstrb and replicated wdata
  - extended load data from the raw word
  - the misalign/illegal error flag

## Test plan
- C load word: memory word 0x100 = 0xDEADBEEF, C LW addr 0x100. Expect c_gnt in cycle 0, mem_en in cycle 1, c_rvalid in cycle 2 with c_rdata = 0xDEADBEEF, err = 0.
- D store byte: SB addr 0x103, wdata 0x000000A5. Expect mem_wstrb = 1000, mem_wdata = 0xA5A5A5A5, then LB 0x103 returns 0xFFFFFFA5 and LBU returns 0x000000A5.
- Tie, round-robin: with DMEM_ARB_RR_EN, hold both requests for 3 grants. Expect grant order C, D, C. Without the macro, expect C, C, C.
- Misaligned: LW addr 0x102 and LH addr 0x101. Expect mem_en = 0 throughout, rvalid with err = 1 and rdata = 0.
- Back-to-back: C requests again in its RESP cycle. Expect c_gnt in that same cycle, with rvalid spaced every 2 cycles.
- Reset in ACCESS: a pending SW is dropped. Expect no mem_we, no rvalid, and all outputs at reset values on the next cycle.
